// File: rtl/cim_pkg.sv
// Shared constants for the compute-in-memory datapath: widths, shift_acc state
// encoding and the activation-precision clamp.
package cim_pkg;

  localparam int MAC_W = 15;
  localparam int NBITS = 8;
  localparam int ACC_W = MAC_W + NBITS;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // A precision of 0 or beyond the supported plane count means "full precision".
  function automatic logic [3:0] clamp_prec(input logic [3:0] p);
    if (p == 4'd0 || p > 4'(NBITS)) return 4'(NBITS);
    return p;
  endfunction

endpackage

// File: rtl/shift_acc.sv
// Bit-serial shift-and-accumulate: folds up to NBITS MAC partial sums, MSB plane
// first, into one dot-product result handed off on a valid/ready port.
module shift_acc
  import cim_pkg::*;
#(
  parameter int MAC_W_P = MAC_W,
  parameter int NBITS_P = NBITS,
  parameter int ACC_W_P = MAC_W_P + NBITS_P
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         prec,
  input  logic               sus,
  input  logic               mac_valid,
  input  logic [MAC_W_P-1:0] mac_in,
  output logic               mac_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W_P-1:0] out_data,
  output logic               busy
);

  logic [1:0]         r_state;
  logic [3:0]         r_cnt;
  logic [3:0]         r_prec;
  logic               r_sus;
  logic [ACC_W_P-1:0] r_acc;
  logic [ACC_W_P-1:0] r_out;

  logic [ACC_W_P-1:0] w_ext;
  logic [ACC_W_P-1:0] w_shl;
  logic [ACC_W_P-1:0] w_sum;
  logic [3:0]         w_cnt_nx;
  logic               w_accept;
  logic               w_launch;

  assign mac_ready = (r_state == ST_ACC);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign out_data  = r_out;

  assign w_accept = mac_ready && mac_valid;
  // A job launches from IDLE, or back-to-back on the result handshake.
  assign w_launch = start && ((r_state == ST_IDLE) || (out_valid && out_ready));

  assign w_ext    = r_sus ? {{NBITS_P{mac_in[MAC_W_P-1]}}, mac_in}
                          : {{NBITS_P{1'b0}}, mac_in};
  assign w_shl    = r_acc << 1;
  // MSB plane carries negative weight in signed mode.
  assign w_sum    = (r_sus && r_cnt == 4'd0) ? (w_shl - w_ext) : (w_shl + w_ext);
  assign w_cnt_nx = r_cnt + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_prec  <= '0;
      r_sus   <= 1'b0;
      r_acc   <= '0;
      r_out   <= '0;
    end else if (w_launch) begin
      r_state <= ST_ACC;
      r_cnt   <= '0;
      r_prec  <= clamp_prec(prec);
      r_sus   <= sus;
      r_acc   <= '0;
    end else if (w_accept) begin
      r_acc <= w_sum;
      r_cnt <= w_cnt_nx;
      if (w_cnt_nx == r_prec) begin
        r_out   <= w_sum;
        r_state <= ST_DONE;
      end
    end else if (out_valid && out_ready) begin
      r_state <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_shift_acc.sv
// Directed bench for shift_acc: hand-computed results, latency, bubbles,
// backpressure, mid-job reset and start-while-busy.
module tb_shift_acc;

  localparam int MW = 15;
  localparam int AW = 23;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [3:0]    prec;
  logic          sus;
  logic          mac_valid;
  logic [MW-1:0] mac_in;
  logic          mac_ready;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  shift_acc dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prec(prec), .sus(sus),
    .mac_valid(mac_valid), .mac_in(mac_in), .mac_ready(mac_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [3:0] p, input logic s);
    start = 1'b1; prec = p; sus = s;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [MW-1:0] v);
    mac_valid = 1'b1; mac_in = v;
    tick();
    mac_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  int lat;
  int acc_n;
  logic [AW-1:0] held;

  initial begin
    rst_n = 1'b0; start = 1'b0; prec = 4'd0; sus = 1'b0;
    mac_valid = 1'b0; mac_in = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_mac_ready", 32'(mac_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  32'(out_data),  0);
    chk("rst_busy",      32'(busy),      0);
    rst_n = 1'b1;
    tick();

    // Unsigned, 8 planes of 100, continuous valid
    launch(4'd8, 1'b0);
    chk("u8_mac_ready", 32'(mac_ready), 1);
    chk("u8_busy",      32'(busy),      1);
    mac_valid = 1'b1; mac_in = 15'd100;
    lat = 1;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    mac_valid = 1'b0;
    chk("u8_latency",   32'(lat),       9);
    chk("u8_data",      32'(out_data),  32'h00639C);
    chk("u8_mac_ready_done", 32'(mac_ready), 0);
    drain();
    chk("u8_idle_valid", 32'(out_valid), 0);
    chk("u8_idle_busy",  32'(busy),      0);

    // Signed, 8 planes of 100 -> -100
    launch(4'd8, 1'b1);
    for (int i = 0; i < 8; i++) feed(15'd100);
    chk("s8_valid", 32'(out_valid), 1);
    chk("s8_data",  32'(out_data),  32'h7FFF9C);
    drain();

    // Signed, 4 planes of -1 -> 1
    launch(4'd4, 1'b1);
    for (int i = 0; i < 4; i++) feed(15'h7FFF);
    chk("s4_valid", 32'(out_valid), 1);
    chk("s4_data",  32'(out_data),  32'h000001);
    drain();

    // prec=0 clamps to 8; bubbles on alternate cycles
    launch(4'd0, 1'b0);
    mac_in = 15'd32760;
    acc_n = 0; lat = 0;
    while (!out_valid && lat < 100) begin
      mac_valid = lat[0] ? 1'b0 : 1'b1;
      if (mac_valid && mac_ready) acc_n++;
      tick(); lat++;
    end
    mac_valid = 1'b0;
    chk("clamp_valid",   32'(out_valid), 1);
    chk("clamp_accepts", 32'(acc_n),     8);
    chk("clamp_data",    32'(out_data),  32'h7F7808);

    // Backpressure with MAC pushing
    held = out_data;
    mac_valid = 1'b1; mac_in = 15'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid",     32'(out_valid), 1);
      chk("bp_mac_ready", 32'(mac_ready), 0);
      chk("bp_data",      32'(out_data),  32'(held));
    end
    mac_valid = 1'b0;
    // Handshake together with start: back-to-back job
    out_ready = 1'b1; start = 1'b1; prec = 4'd2; sus = 1'b0;
    tick();
    out_ready = 1'b0; start = 1'b0;
    chk("b2b_mac_ready", 32'(mac_ready), 1);
    chk("b2b_out_valid", 32'(out_valid), 0);
    feed(15'd5); feed(15'd3);
    chk("b2b_data", 32'(out_data), 13);
    drain();

    // Reset mid-job
    launch(4'd8, 1'b0);
    feed(15'd9); feed(15'd9); feed(15'd9);
    rst_n = 1'b0;
    #1;
    chk("mrst_mac_ready", 32'(mac_ready), 0);
    chk("mrst_out_valid", 32'(out_valid), 0);
    chk("mrst_out_data",  32'(out_data),  0);
    chk("mrst_busy",      32'(busy),      0);
    tick();
    rst_n = 1'b1;
    tick();
    launch(4'd2, 1'b0);
    feed(15'd5); feed(15'd3);
    chk("post_rst_valid", 32'(out_valid), 1);
    chk("post_rst_data",  32'(out_data),  13);
    drain();

    // start pulsed mid-job must not restart or change precision
    launch(4'd4, 1'b0);
    start = 1'b1; prec = 4'd1;
    feed(15'd1);
    start = 1'b0;
    chk("busy_start_not_done", 32'(out_valid), 0);
    acc_n = 1; lat = 0;
    mac_valid = 1'b1;
    while (!out_valid && lat < 50) begin
      mac_in = 15'(acc_n + 1);
      if (mac_ready) acc_n++;
      tick(); lat++;
    end
    mac_valid = 1'b0;
    chk("busy_start_accepts", 32'(acc_n), 4);
    chk("busy_start_data",    32'(out_data), 26);
    drain();
    chk("final_idle", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
